holy_axi_arbiter: RTL and testbench
===================================

Name: holy_axi_arbiter

Overview:
- Shares the core's single external AXI master port between the instruction cache and the data cache.
- Each cache exports its `cache_state_t`. The arbiter grants the bus to one cache for a whole miss/write-back/flush sequence, then releases it.
- Sits between the two `holy_cache` instances and the top-level AXI master; no data buffering.
- Channels are muxed combinationally from a registered grant.

Parameters:
- TIMEOUT_CYCLES, 4096, max cycles a single grant may be held before `timeout_err` sets; 0 disables the watchdog.
- CNT_W, 16, watchdog counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  core/AXI clock
- rst  in  1  synchronous, active-high reset
- s_axi_instr  axi_if.slave  -  instruction-cache AXI port
- s_axi_data  axi_if.slave  -  data-cache AXI port
- m_axi  axi_if.master  -  external AXI master
- i_cache_state  in  cache_state_t  instruction-cache FSM state
- d_cache_state  in  cache_state_t  data-cache FSM state
- grant_instr  out  1  registered: instruction cache owns the bus
- grant_data  out  1  registered: data cache owns the bus
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clocking and reset: one clock, `clk`; reset is synchronous and active-high (`rst`).
- Request definition:
  - req_i = (i_cache_state != IDLE)
  - req_d = (d_cache_state != IDLE)
- FSM (`arb_state_t`): ARB_IDLE, ARB_INSTR, ARB_DATA.
- ARB_IDLE:
  - req_i only -> ARB_INSTR.
  - req_d only -> ARB_DATA.
  - Both -> the requester not served last (round-robin).
  - `last_grant` resets to DATA, so instr wins the first tie.
- ARB_INSTR: stay while req_i; when i_cache_state == IDLE -> ARB_IDLE and last_grant <= INSTR.
- ARB_DATA: symmetric, using d_cache_state.
- Grant holds for the full cache sequence: write request, write data, write response, read request, read data, including a csr flush.
- No re-arbitration mid-sequence and no direct INSTR->DATA hop; one ARB_IDLE cycle always separates grants.
- Latency: cache leaves IDLE at edge N -> grant flop set at edge N+1 -> m_axi.awvalid/arvalid visible in cycle N+1.
- The requesting cache holds arvalid/awvalid until accepted, so no handshake is lost.
- Muxing when granted X:
  - All AW/W/AR master-bound signals (valid, addr, len, size, burst, id, wdata, wstrb, wlast, bready, rready) come from X.
  - All slave-bound signals (awready, wready, arready, bvalid, bresp, rvalid, rdata, rlast, rresp) go to X only.
  - The non-granted slave sees every ready/valid = 0; its data fields are don't-care and are driven to 0.
- ARB_IDLE: m_axi awvalid/wvalid/arvalid/bready/rready = 0; every slave ready/valid = 0.
- Release timing: the cache returns to IDLE on the same edge as the final rlast handshake. The arbiter observes this the next cycle, so there is 1 idle bus cycle after each transaction. This is acceptable and intended.
- Watchdog:
  - `cnt` clears on entry to ARB_IDLE and increments each granted cycle, saturating.
  - When cnt == TIMEOUT_CYCLES, `timeout_err` <= 1 and stays set until rst.
  - Grant is not revoked: this is diagnostic only.
- Reset values: state ARB_IDLE, grant_instr = 0, grant_data = 0, last_grant = DATA, cnt = 0, timeout_err = 0, all m_axi valids/readys = 0.
- Reset mid-transaction: the arbiter drops to ARB_IDLE in one cycle and the slave handshakes go silent. The caches and memory share the same reset, so no protocol recovery is required.
- Invariant: grant_instr & grant_data never both 1. The bench asserts this.
- Unknown/default FSM state -> ARB_IDLE.

Decomposition:
- In holy_core_pkg:
  - `arb_state_t` enum {ARB_IDLE, ARB_INSTR, ARB_DATA}
  - `arb_owner_t` enum {OWNER_INSTR, OWNER_DATA} for last_grant
- `cache_state_t` already lives there.
- One sub-module is natural: holy_axi_port_mux.
  - Purely combinational 2:1 AXI channel mux/demux driven by a one-hot select.
  - Reused later for a peripheral port.
- FSM and watchdog stay in holy_axi_arbiter.

Test Plan:
- Instr-only miss: i_cache_state -> SENDING_READ_REQ at cycle 5 -> grant_instr = 1 at cycle 6. m_axi.araddr = instr araddr, arlen = 127. 128 beats routed to s_axi_instr only. grant drops the cycle after i_cache_state returns to IDLE.
- Simultaneous requests right after reset: both leave IDLE at the same cycle -> instr granted first. Data granted after instr returns to IDLE + 1 ARB_IDLE cycle. s_axi_data.arready stays 0 throughout the instr burst.
- Back-to-back round robin: instr then data then instr both pending -> grant order I, D, I. The next tie goes to the one not served last.
- Dirty data-cache flush: d_cache_state SENDING_WRITE_REQ -> ... -> RECEIVING_READ_DATA. The grant is held across AW, 128 W beats (wlast on beat 128), B OKAY and the 128-beat read. A concurrent instr request waits the whole time.
- Watchdog: TIMEOUT_CYCLES = 20, memory never asserts arready -> timeout_err = 1 at grant cycle 20. grant_data stays 1. timeout_err stays 1 after the request completes, until rst.
- Reset mid-burst: assert rst at beat 40 of an instr read -> next cycle grant_instr = 0, state ARB_IDLE, m_axi.rready = 0, timeout_err = 0.

Source files
------------

// File: rtl/holy_core_pkg.sv
// Shared core types: cache FSM states, AXI field widths and arbiter state/owner enums.
package holy_core_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SENDING_WRITE_REQ,
    SENDING_WRITE_DATA,
    WAITING_WRITE_RES,
    SENDING_READ_REQ,
    RECEIVING_READ_DATA
  } cache_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_INSTR,
    ARB_DATA
  } arb_state_t;

  typedef enum logic {
    OWNER_INSTR,
    OWNER_DATA
  } arb_owner_t;

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle used between the caches, the arbiter and the external master port.
interface axi_if;
  import holy_core_pkg::*;

  logic                  awvalid;
  logic                  awready;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [AXI_LEN_W-1:0]  awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [AXI_ID_W-1:0]   awid;

  logic                    wvalid;
  logic                    wready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;

  logic       bvalid;
  logic       bready;
  logic [1:0] bresp;

  logic                  arvalid;
  logic                  arready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_LEN_W-1:0]  arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [AXI_ID_W-1:0]   arid;

  logic                  rvalid;
  logic                  rready;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/holy_axi_port_mux.sv
// Combinational 2:1 AXI mux/demux. sel is one-hot (bit0 = port a, bit1 = port b);
// with no select the master sees idle channels and both slaves see zeros.
module holy_axi_port_mux (
  input  logic  [1:0] sel,
  axi_if.slave  s_a,
  axi_if.slave  s_b,
  axi_if.master m
);

  logic sel_a, sel_b;

  // Port a wins an illegal double select so both directions agree on one owner.
  assign sel_a = sel[0];
  assign sel_b = sel[1] & ~sel[0];

  always_comb begin
    m.awvalid = 1'b0;
    m.awaddr  = '0;
    m.awlen   = '0;
    m.awsize  = '0;
    m.awburst = '0;
    m.awid    = '0;
    m.wvalid  = 1'b0;
    m.wdata   = '0;
    m.wstrb   = '0;
    m.wlast   = 1'b0;
    m.bready  = 1'b0;
    m.arvalid = 1'b0;
    m.araddr  = '0;
    m.arlen   = '0;
    m.arsize  = '0;
    m.arburst = '0;
    m.arid    = '0;
    m.rready  = 1'b0;
    if (sel_a) begin
      m.awvalid = s_a.awvalid;
      m.awaddr  = s_a.awaddr;
      m.awlen   = s_a.awlen;
      m.awsize  = s_a.awsize;
      m.awburst = s_a.awburst;
      m.awid    = s_a.awid;
      m.wvalid  = s_a.wvalid;
      m.wdata   = s_a.wdata;
      m.wstrb   = s_a.wstrb;
      m.wlast   = s_a.wlast;
      m.bready  = s_a.bready;
      m.arvalid = s_a.arvalid;
      m.araddr  = s_a.araddr;
      m.arlen   = s_a.arlen;
      m.arsize  = s_a.arsize;
      m.arburst = s_a.arburst;
      m.arid    = s_a.arid;
      m.rready  = s_a.rready;
    end else if (sel_b) begin
      m.awvalid = s_b.awvalid;
      m.awaddr  = s_b.awaddr;
      m.awlen   = s_b.awlen;
      m.awsize  = s_b.awsize;
      m.awburst = s_b.awburst;
      m.awid    = s_b.awid;
      m.wvalid  = s_b.wvalid;
      m.wdata   = s_b.wdata;
      m.wstrb   = s_b.wstrb;
      m.wlast   = s_b.wlast;
      m.bready  = s_b.bready;
      m.arvalid = s_b.arvalid;
      m.araddr  = s_b.araddr;
      m.arlen   = s_b.arlen;
      m.arsize  = s_b.arsize;
      m.arburst = s_b.arburst;
      m.arid    = s_b.arid;
      m.rready  = s_b.rready;
    end
  end

  assign s_a.awready = sel_a & m.awready;
  assign s_a.wready  = sel_a & m.wready;
  assign s_a.bvalid  = sel_a & m.bvalid;
  assign s_a.bresp   = sel_a ? m.bresp : '0;
  assign s_a.arready = sel_a & m.arready;
  assign s_a.rvalid  = sel_a & m.rvalid;
  assign s_a.rdata   = sel_a ? m.rdata : '0;
  assign s_a.rresp   = sel_a ? m.rresp : '0;
  assign s_a.rlast   = sel_a & m.rlast;

  assign s_b.awready = sel_b & m.awready;
  assign s_b.wready  = sel_b & m.wready;
  assign s_b.bvalid  = sel_b & m.bvalid;
  assign s_b.bresp   = sel_b ? m.bresp : '0;
  assign s_b.arready = sel_b & m.arready;
  assign s_b.rvalid  = sel_b & m.rvalid;
  assign s_b.rdata   = sel_b ? m.rdata : '0;
  assign s_b.rresp   = sel_b ? m.rresp : '0;
  assign s_b.rlast   = sel_b & m.rlast;

endmodule

// File: rtl/holy_axi_arbiter.sv
// Shares the single external AXI master between I$ and D$. A grant covers a whole
// cache sequence; round-robin on ties; sticky watchdog flag for stuck grants.
module holy_axi_arbiter
  import holy_core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,  // 0 disables; must be < 2**CNT_W
  parameter int CNT_W          = 16
) (
  input  logic         clk,
  input  logic         rst,
  axi_if.slave         s_axi_instr,
  axi_if.slave         s_axi_data,
  axi_if.master        m_axi,
  input  cache_state_t i_cache_state,
  input  cache_state_t d_cache_state,
  output logic         grant_instr,
  output logic         grant_data,
  output logic         timeout_err
);

  localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               WD_EN = (TIMEOUT_CYCLES != 0);

  arb_state_t       state;
  arb_owner_t       last_grant;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             req_i, req_d, wd_hit;

  assign req_i = (i_cache_state != IDLE);
  assign req_d = (d_cache_state != IDLE);

  // cnt equals the number of the current granted cycle, so the flag is
  // visible during the TIMEOUT_CYCLES-th cycle of a grant.
  assign cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
  assign wd_hit  = WD_EN && (cnt_nxt == TO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      grant_instr <= 1'b0;
      grant_data  <= 1'b0;
      last_grant  <= OWNER_DATA;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          cnt <= '0;
          if (req_i && (!req_d || last_grant == OWNER_DATA)) begin
            state       <= ARB_INSTR;
            grant_instr <= 1'b1;
            cnt         <= cnt_nxt;
            if (wd_hit) timeout_err <= 1'b1;
          end else if (req_d) begin
            state      <= ARB_DATA;
            grant_data <= 1'b1;
            cnt        <= cnt_nxt;
            if (wd_hit) timeout_err <= 1'b1;
          end
        end
        ARB_INSTR: begin
          if (req_i) begin
            cnt <= cnt_nxt;
            if (wd_hit) timeout_err <= 1'b1;
          end else begin
            state       <= ARB_IDLE;
            grant_instr <= 1'b0;
            last_grant  <= OWNER_INSTR;
            cnt         <= '0;
          end
        end
        ARB_DATA: begin
          if (req_d) begin
            cnt <= cnt_nxt;
            if (wd_hit) timeout_err <= 1'b1;
          end else begin
            state      <= ARB_IDLE;
            grant_data <= 1'b0;
            last_grant <= OWNER_DATA;
            cnt        <= '0;
          end
        end
        default: begin
          state       <= ARB_IDLE;
          grant_instr <= 1'b0;
          grant_data  <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

  holy_axi_port_mux u_mux (
    .sel ({grant_data, grant_instr}),
    .s_a (s_axi_instr),
    .s_b (s_axi_data),
    .m   (m_axi)
  );

endmodule

// File: tb/tb_holy_axi_arbiter.sv
// Directed bench: two cache models drive the slave ports, a scripted memory drives m_axi.
module tb_holy_axi_arbiter;
  import holy_core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_if ai ();
  axi_if ad ();
  axi_if am ();

  cache_state_t cst [2];
  logic [1:0]   c_awvalid, c_wvalid, c_wlast, c_bready, c_arvalid, c_rready;
  logic [31:0]  c_addr [2];
  logic [31:0]  c_wdata [2];
  logic         grant_instr, grant_data, timeout_err;

  holy_axi_arbiter #(.TIMEOUT_CYCLES(20), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_instr   (ai),
    .s_axi_data    (ad),
    .m_axi         (am),
    .i_cache_state (cst[0]),
    .d_cache_state (cst[1]),
    .grant_instr   (grant_instr),
    .grant_data    (grant_data),
    .timeout_err   (timeout_err)
  );

  assign ai.awvalid = c_awvalid[0];
  assign ai.awaddr  = c_addr[0];
  assign ai.awlen   = 8'd127;
  assign ai.awsize  = 3'd2;
  assign ai.awburst = 2'b01;
  assign ai.awid    = 4'd0;
  assign ai.wvalid  = c_wvalid[0];
  assign ai.wdata   = c_wdata[0];
  assign ai.wstrb   = 4'hf;
  assign ai.wlast   = c_wlast[0];
  assign ai.bready  = c_bready[0];
  assign ai.arvalid = c_arvalid[0];
  assign ai.araddr  = c_addr[0];
  assign ai.arlen   = 8'd127;
  assign ai.arsize  = 3'd2;
  assign ai.arburst = 2'b01;
  assign ai.arid    = 4'd0;
  assign ai.rready  = c_rready[0];

  assign ad.awvalid = c_awvalid[1];
  assign ad.awaddr  = c_addr[1];
  assign ad.awlen   = 8'd127;
  assign ad.awsize  = 3'd2;
  assign ad.awburst = 2'b01;
  assign ad.awid    = 4'd1;
  assign ad.wvalid  = c_wvalid[1];
  assign ad.wdata   = c_wdata[1];
  assign ad.wstrb   = 4'h5;
  assign ad.wlast   = c_wlast[1];
  assign ad.bready  = c_bready[1];
  assign ad.arvalid = c_arvalid[1];
  assign ad.araddr  = c_addr[1];
  assign ad.arlen   = 8'd127;
  assign ad.arsize  = 3'd2;
  assign ad.arburst = 2'b01;
  assign ad.arid    = 4'd1;
  assign ad.rready  = c_rready[1];

  logic [1:0]  gr, o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
  logic [31:0] o_rdata [2];
  logic [1:0]  o_rresp [2];
  logic [1:0]  o_bresp [2];
  assign gr        = {grant_data, grant_instr};
  assign o_awready = {ad.awready, ai.awready};
  assign o_wready  = {ad.wready,  ai.wready};
  assign o_bvalid  = {ad.bvalid,  ai.bvalid};
  assign o_arready = {ad.arready, ai.arready};
  assign o_rvalid  = {ad.rvalid,  ai.rvalid};
  assign o_rlast   = {ad.rlast,   ai.rlast};
  assign o_rdata[0] = ai.rdata;
  assign o_rdata[1] = ad.rdata;
  assign o_rresp[0] = ai.rresp;
  assign o_rresp[1] = ad.rresp;
  assign o_bresp[0] = ai.bresp;
  assign o_bresp[1] = ad.bresp;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle monitor: grant exclusivity, silent non-granted slaves, grant order log.
  int          leak = 0;
  int          gi_cycles = 0;
  logic [31:0] glog = '0;
  logic        gi_q = 1'b0, gd_q = 1'b0;
  always @(negedge clk) begin
    chk("excl", 32'(grant_instr & grant_data), 32'd0);
    for (int c = 0; c < 2; c++)
      if (!gr[c] && (o_awready[c] | o_wready[c] | o_bvalid[c] | o_arready[c] | o_rvalid[c]))
        leak++;
    if (gr == 2'b00 && (am.awvalid | am.wvalid | am.arvalid | am.bready | am.rready))
      leak++;
    if (grant_instr) gi_cycles++;
    if (grant_instr && !gi_q) glog = {glog[29:0], 2'b01};
    if (grant_data && !gd_q)  glog = {glog[29:0], 2'b10};
    gi_q = grant_instr;
    gd_q = grant_data;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic raise(input int c, input logic [31:0] addr);
    cst[c]       = SENDING_READ_REQ;
    c_arvalid[c] = 1'b1;
    c_addr[c]    = addr;
  endtask

  task automatic wait_grant(input int c);
    int n = 0;
    while (!gr[c] && n < 50) begin
      step;
      n++;
    end
    chk("gnt_wait", 32'(gr[c]), 32'd1);
  endtask

  // Read burst; beats < 128 stops early with rvalid still driven.
  task automatic serve_read(input int c, input logic [31:0] base, input int beats);
    int         good;
    logic [1:0] msk;
    msk = 2'b01 << c;
    wait_grant(c);
    am.arready = 1'b1;
    settle;
    chk("ar_route", 32'(o_arready), 32'(msk));
    chk("ar_addr", am.araddr, c_addr[c]);
    step;
    am.arready   = 1'b0;
    c_arvalid[c] = 1'b0;
    cst[c]       = RECEIVING_READ_DATA;
    c_rready[c]  = 1'b1;
    good = 0;
    for (int b = 0; b < beats; b++) begin
      am.rvalid = 1'b1;
      am.rdata  = base + 32'(b);
      am.rlast  = (b == 127);
      settle;
      if (o_rvalid == msk && am.rready && o_rdata[c] == base + 32'(b) &&
          o_rlast[c] == (b == 127) && o_rresp[c] == 2'b00)
        good++;
      step;
      if (b == 127) begin
        cst[c]      = IDLE;
        c_rready[c] = 1'b0;
        am.rvalid   = 1'b0;
        am.rlast    = 1'b0;
      end
    end
    chk("r_beats", 32'(good), 32'(beats));
  endtask

  task automatic serve_write(input int c, input logic [31:0] base);
    int         good;
    logic [1:0] msk;
    msk = 2'b01 << c;
    wait_grant(c);
    am.awready = 1'b1;
    settle;
    chk("aw_route", 32'(o_awready), 32'(msk));
    chk("aw_addr", am.awaddr, c_addr[c]);
    chk("aw_len_id", {am.awid, am.awburst, am.awsize, am.awlen}, {4'(c), 2'b01, 3'd2, 8'd127});
    step;
    am.awready   = 1'b0;
    c_awvalid[c] = 1'b0;
    cst[c]       = SENDING_WRITE_DATA;
    c_wvalid[c]  = 1'b1;
    am.wready    = 1'b1;
    good = 0;
    for (int b = 0; b < 128; b++) begin
      c_wdata[c] = base + 32'(b);
      c_wlast[c] = (b == 127);
      settle;
      if (am.wvalid && o_wready == msk && am.wdata == base + 32'(b) &&
          am.wlast == (b == 127) && am.wstrb == ((c == 1) ? 4'h5 : 4'hf))
        good++;
      step;
    end
    chk("w_beats", 32'(good), 32'd128);
    c_wvalid[c] = 1'b0;
    c_wlast[c]  = 1'b0;
    am.wready   = 1'b0;
    cst[c]      = WAITING_WRITE_RES;
    c_bready[c] = 1'b1;
    am.bvalid   = 1'b1;
    am.bresp    = 2'b00;
    settle;
    chk("b_route", 32'(o_bvalid), 32'(msk));
    chk("b_ready", 32'(am.bready), 32'd1);
    chk("b_resp", 32'(o_bresp[c]), 32'd0);
    step;
    am.bvalid    = 1'b0;
    c_bready[c]  = 1'b0;
    cst[c]       = SENDING_READ_REQ;
    c_arvalid[c] = 1'b1;
    serve_read(c, base + 32'h1000, 128);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int gi0;
    for (int c = 0; c < 2; c++) begin
      cst[c] = IDLE;
      c_addr[c] = '0;
      c_wdata[c] = '0;
    end
    {c_awvalid, c_wvalid, c_wlast, c_bready, c_arvalid, c_rready} = '0;
    am.awready = 1'b0; am.wready = 1'b0; am.bvalid = 1'b0; am.bresp = 2'b00;
    am.arready = 1'b0; am.rvalid = 1'b0; am.rdata = '0; am.rresp = 2'b00; am.rlast = 1'b0;

    // Reset state
    repeat (3) step;
    settle;
    chk("rst_grants", 32'(gr), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_mvalid", {am.awvalid, am.wvalid, am.arvalid, am.bready, am.rready}, 32'd0);
    rst = 1'b0;
    step;

    // Watchdog: D$ granted, memory stalls arready
    raise(1, 32'h2000);
    wait_grant(1);
    repeat (18) step;
    settle;
    chk("wd_cycle19", 32'(timeout_err), 32'd0);
    step;
    settle;
    chk("wd_cycle20", 32'(timeout_err), 32'd1);
    chk("wd_hold", 32'(grant_data), 32'd1);
    serve_read(1, 32'hd000, 128);
    step;
    step;
    settle;
    chk("wd_sticky", 32'(timeout_err), 32'd1);
    chk("wd_release", 32'(gr), 32'd0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    settle;
    chk("wd_clear", 32'(timeout_err), 32'd0);

    // I$-only miss: latency and routing
    step;
    raise(0, 32'h1000);
    settle;
    chk("i_lat_n", {30'd0, gr}, 32'd0);
    chk("i_arv_n", 32'(am.arvalid), 32'd0);
    step;
    chk("i_gnt", 32'(gr), 32'b01);
    chk("i_arv", 32'(am.arvalid), 32'd1);
    chk("i_arfmt", {am.arid, am.arburst, am.arsize, am.arlen}, {4'd0, 2'b01, 3'd2, 8'd127});
    serve_read(0, 32'ha000, 128);
    settle;
    chk("i_hold", 32'(grant_instr), 32'd1);
    step;
    chk("i_rel", 32'(grant_instr), 32'd0);

    // Simultaneous after reset: instr first, one idle cycle, then data
    rst = 1'b1;
    step;
    rst = 1'b0;
    raise(0, 32'h1100);
    raise(1, 32'h2200);
    step;
    chk("tie_i", 32'(gr), 32'b01);
    serve_read(0, 32'hb000, 128);
    step;
    chk("tie_gap", 32'(gr), 32'b00);
    step;
    chk("tie_d", 32'(gr), 32'b10);
    serve_read(1, 32'hc000, 128);
    step;

    // Round robin: I, D, I, then next tie goes to D
    raise(0, 32'h1200);
    raise(1, 32'h2300);
    step;
    chk("rr_i1", 32'(gr), 32'b01);
    serve_read(0, 32'he000, 128);
    step;
    raise(0, 32'h1300);
    step;
    chk("rr_d", 32'(gr), 32'b10);
    serve_read(1, 32'hf000, 128);
    step;
    step;
    chk("rr_i2", 32'(gr), 32'b01);
    serve_read(0, 32'h9000, 128);
    chk("rr_order", 32'(glog[5:0]), 32'b011001);
    step;
    raise(0, 32'h1400);
    raise(1, 32'h2400);
    step;
    chk("rr_tie", 32'(gr), 32'b10);
    serve_read(1, 32'h8000, 128);
    step;
    step;
    serve_read(0, 32'h7000, 128);
    step;

    // Dirty D$ flush with I$ waiting
    cst[1]       = SENDING_WRITE_REQ;
    c_awvalid[1] = 1'b1;
    c_addr[1]    = 32'h3000;
    step;
    raise(0, 32'h1500);
    gi0 = gi_cycles;
    serve_write(1, 32'h5000);
    chk("fl_i_wait", 32'(gi_cycles - gi0), 32'd0);
    step;
    step;
    chk("fl_i_next", 32'(gr), 32'b01);
    serve_read(0, 32'h6000, 128);
    step;

    // Reset at beat 40 of an I$ read
    raise(0, 32'h1600);
    step;
    serve_read(0, 32'h4000, 40);
    chk("mr_err_pre", 32'(timeout_err), 32'd1);
    rst = 1'b1;
    step;
    settle;
    chk("mr_grants", 32'(gr), 32'd0);
    chk("mr_rready", 32'(am.rready), 32'd0);
    chk("mr_rvalid", 32'(o_rvalid), 32'd0);
    chk("mr_err", 32'(timeout_err), 32'd0);
    cst[0] = IDLE;
    c_rready = '0;
    am.rvalid = 1'b0;
    rst = 1'b0;
    step;
    step;

    chk("slave_silence", 32'(leak), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
